// File: rtl/riscv_perf_monitor.sv
// Performance/halt monitor on the core debug bus: saturating counters plus loop and timeout halt detection.
// Latency: all outputs are registered and update on the edge after the sampled inputs; done follows state combinationally.
// Backpressure: none, because the monitor only observes the bus; once halted it freezes until reset or clear.
module riscv_perf_monitor #(
  parameter int CNT_WIDTH      = 32,
  parameter int LOOP_THRESH    = 5,
  parameter int NUM_EVT        = 4,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          clear,
  input  logic [31:0]                   debug_pc,
  input  logic [31:0]                   debug_instr,
  input  logic                          debug_stall,
  input  logic                          debug_branch_taken,
  input  logic [NUM_EVT-1:0]            evt_in,
  output logic [CNT_WIDTH-1:0]          cycle_count,
  output logic [CNT_WIDTH-1:0]          instr_count,
  output logic [CNT_WIDTH-1:0]          stall_count,
  output logic [CNT_WIDTH-1:0]          branch_count,
  output logic [NUM_EVT*CNT_WIDTH-1:0]  evt_count,
  output logic                          overflow,
  output logic [1:0]                    state,
  output logic                          done,
  output logic [31:0]                   loop_pc
);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_RUN          = 2'd1,
    ST_HALT_LOOP    = 2'd2,
    ST_HALT_TIMEOUT = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [8:0]           LOOP_LIM    = 9'(LOOP_THRESH);
  localparam logic [63:0]          TIMEOUT_LIM = 64'(TIMEOUT_CYCLES);
  localparam logic [31:0]          INSTR_NOP   = 32'h0000_0013;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cycle_q, instr_q, stall_q, branch_q;
  logic [CNT_WIDTH-1:0]   evt_q [NUM_EVT];
  logic [31:0]            prev_pc, prev_instr;
  logic [8:0]             match_cnt;

  logic                   running;
  logic                   instr_valid;
  logic                   retire;
  logic                   sample_match;
  logic [8:0]             match_inc;
  logic                   loop_hit;
  logic                   timeout_hit;
  logic [CNT_WIDTH-1:0]   cycle_nx;
  logic                   evt_sat;
  logic                   any_sat;

  // Increment unless already at all-ones; a saturated counter simply holds.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic en);
    return (en && (v != CNT_MAX)) ? v + CNT_WIDTH'(1) : v;
  endfunction

  // An increment request that lands on an all-ones counter is what marks overflow.
  function automatic logic sat_hit(input logic [CNT_WIDTH-1:0] v, input logic en);
    return en && (v == CNT_MAX);
  endfunction

  assign running      = (state_q == ST_RUN);
  assign instr_valid  = (debug_instr != 32'd0);
  assign retire       = instr_valid && (debug_instr != INSTR_NOP) && !debug_stall;
  assign sample_match = (debug_pc == prev_pc) && (debug_instr == prev_instr);
  assign match_inc    = match_cnt + 9'd1;
  // A zero instruction is a bubble, so it neither advances nor breaks a loop run.
  assign loop_hit     = running && instr_valid && sample_match && (match_inc == LOOP_LIM);
  assign cycle_nx     = sat_inc(cycle_q, 1'b1);
  // Compare against the post-increment count so the halt lands exactly on the limit.
  assign timeout_hit  = running && (TIMEOUT_CYCLES != 0) && (64'(cycle_nx) == TIMEOUT_LIM);

  // Collect saturation hits across the generic event counters.
  always_comb begin
    evt_sat = 1'b0;
    for (int i = 0; i < NUM_EVT; i++) begin
      evt_sat = evt_sat | sat_hit(evt_q[i], evt_in[i]);
    end
  end

  assign any_sat = sat_hit(cycle_q, 1'b1) | sat_hit(instr_q, retire) |
                   sat_hit(stall_q, debug_stall) | sat_hit(branch_q, debug_branch_taken) |
                   evt_sat;

  // Next-state: arm on a live instruction, loop halt outranks timeout, halts are terminal.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && instr_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (loop_hit)         state_d = ST_HALT_LOOP;
        else if (timeout_hit) state_d = ST_HALT_TIMEOUT;
      end
      default: state_d = state_q;
    endcase
  end

  // State register; clear behaves exactly like reset.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) state_q <= ST_IDLE;
    else                 state_q <= state_d;
  end

  // Counters and loop tracking advance only in RUN, including the halting edge itself.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cycle_q    <= '0;
      instr_q    <= '0;
      stall_q    <= '0;
      branch_q   <= '0;
      for (int i = 0; i < NUM_EVT; i++) evt_q[i] <= '0;
      overflow   <= 1'b0;
      loop_pc    <= 32'd0;
      prev_pc    <= 32'd0;
      prev_instr <= 32'd0;
      match_cnt  <= 9'd0;
    end else if (running) begin
      cycle_q  <= cycle_nx;
      instr_q  <= sat_inc(instr_q, retire);
      stall_q  <= sat_inc(stall_q, debug_stall);
      branch_q <= sat_inc(branch_q, debug_branch_taken);
      for (int i = 0; i < NUM_EVT; i++) evt_q[i] <= sat_inc(evt_q[i], evt_in[i]);
      if (any_sat) overflow <= 1'b1;
      if (instr_valid) begin
        prev_pc    <= debug_pc;
        prev_instr <= debug_instr;
        match_cnt  <= sample_match ? match_inc : 9'd0;
      end
      if (loop_hit) loop_pc <= debug_pc;
    end
  end

  // Flatten the event counter array onto the packed output bus.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_EVT; gi++) begin : g_evt_out
      assign evt_count[gi*CNT_WIDTH +: CNT_WIDTH] = evt_q[gi];
    end
  endgenerate

  assign cycle_count  = cycle_q;
  assign instr_count  = instr_q;
  assign stall_count  = stall_q;
  assign branch_count = branch_q;
  assign state        = state_q;
  assign done         = state_q[1];

endmodule

// File: tb/tb_riscv_perf_monitor.sv
// Directed bench for riscv_perf_monitor: a 32-bit instance with a short timeout and a 4-bit instance without timeout.
// Latency: inputs are driven 1 ns after each rising edge and outputs checked at that same point.
// Backpressure: not applicable; both instances share one stimulus stream.
module tb_riscv_perf_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        clear;
  logic [31:0] debug_pc;
  logic [31:0] debug_instr;
  logic        debug_stall;
  logic        debug_branch_taken;
  logic [3:0]  evt_in;

  logic [31:0]  m_cycle, m_instr, m_stall, m_branch, m_loop_pc;
  logic [127:0] m_evt;
  logic         m_overflow, m_done;
  logic [1:0]   m_state;

  logic [3:0]   s_cycle, s_instr, s_stall, s_branch;
  logic [31:0]  s_loop_pc;
  logic [15:0]  s_evt;
  logic         s_overflow, s_done;
  logic [1:0]   s_state;

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  riscv_perf_monitor #(
    .CNT_WIDTH(32), .LOOP_THRESH(5), .NUM_EVT(4), .TIMEOUT_CYCLES(16)
  ) u_main (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .debug_pc(debug_pc), .debug_instr(debug_instr), .debug_stall(debug_stall),
    .debug_branch_taken(debug_branch_taken), .evt_in(evt_in),
    .cycle_count(m_cycle), .instr_count(m_instr), .stall_count(m_stall),
    .branch_count(m_branch), .evt_count(m_evt), .overflow(m_overflow),
    .state(m_state), .done(m_done), .loop_pc(m_loop_pc)
  );

  riscv_perf_monitor #(
    .CNT_WIDTH(4), .LOOP_THRESH(5), .NUM_EVT(4), .TIMEOUT_CYCLES(0)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .debug_pc(debug_pc), .debug_instr(debug_instr), .debug_stall(debug_stall),
    .debug_branch_taken(debug_branch_taken), .evt_in(evt_in),
    .cycle_count(s_cycle), .instr_count(s_instr), .stall_count(s_stall),
    .branch_count(s_branch), .evt_count(s_evt), .overflow(s_overflow),
    .state(s_state), .done(s_done), .loop_pc(s_loop_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0;
    debug_pc = 32'd0; debug_instr = 32'd0; debug_stall = 1'b0;
    debug_branch_taken = 1'b0; evt_in = 4'd0;

    // Reset held for two edges
    tick();
    tick();
    check("rst_state",    32'(m_state), 32'd0);
    check("rst_done",     32'(m_done), 32'd0);
    check("rst_cycle",    m_cycle, 32'd0);
    check("rst_overflow", 32'(m_overflow), 32'd0);
    check("rst_loop_pc",  m_loop_pc, 32'd0);

    // Arm: counts stay zero on the arming edge
    rst_n = 1'b1; enable = 1'b1; debug_instr = 32'h0000_0033; debug_pc = 32'h100;
    tick();
    check("arm_state", 32'(m_state), 32'd1);
    check("arm_cycle", m_cycle, 32'd0);
    check("arm_instr", m_instr, 32'd0);
    // Dropping enable in RUN changes nothing
    enable = 1'b0; debug_pc = 32'h104;
    tick();
    check("run1_cycle", m_cycle, 32'd1);
    check("run1_instr", m_instr, 32'd1);
    check("run1_state", 32'(m_state), 32'd1);

    // Mix of ADD/NOP with stalls, branches and events
    do_clear();
    check("clr_state", 32'(m_state), 32'd0);
    check("clr_cycle", m_cycle, 32'd0);
    enable = 1'b1; debug_pc = 32'h200; debug_instr = 32'h0000_0033;
    tick();
    for (int i = 0; i < 10; i++) begin
      debug_pc           = 32'h200 + 32'(4 * i);
      debug_instr        = (i % 2 == 0) ? 32'h0000_0033 : 32'h0000_0013;
      debug_stall        = (i == 2) || (i == 6);
      debug_branch_taken = (i == 1) || (i == 5) || (i == 9);
      evt_in             = 4'(i);
      tick();
    end
    debug_stall = 1'b0; debug_branch_taken = 1'b0; evt_in = 4'd0;
    check("mix_cycle",  m_cycle, 32'd10);
    check("mix_instr",  m_instr, 32'd3);
    check("mix_stall",  m_stall, 32'd2);
    check("mix_branch", m_branch, 32'd3);
    check("mix_evt0",   m_evt[31:0], 32'd5);
    check("mix_evt1",   m_evt[63:32], 32'd4);
    check("mix_evt2",   m_evt[95:64], 32'd4);
    check("mix_evt3",   m_evt[127:96], 32'd2);

    // Loop halt: constant PC/instr from RUN entry
    do_clear();
    enable = 1'b1; debug_pc = 32'h40; debug_instr = 32'h0000_006F;
    tick();
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) begin
        check("loop_pre_done",  32'(m_done), 32'd0);
        check("loop_pre_state", 32'(m_state), 32'd1);
      end
    end
    check("loop_done",  32'(m_done), 32'd1);
    check("loop_state", 32'(m_state), 32'd2);
    check("loop_pc",    m_loop_pc, 32'h40);
    check("loop_cycle", m_cycle, 32'd6);
    check("loop_instr", m_instr, 32'd6);
    for (int k = 0; k < 10; k++) begin
      debug_pc = 32'h80 + 32'(4 * k); debug_stall = 1'b1; evt_in = 4'hF;
      tick();
    end
    debug_stall = 1'b0; evt_in = 4'd0;
    check("frz_cycle", m_cycle, 32'd6);
    check("frz_instr", m_instr, 32'd6);
    check("frz_stall", m_stall, 32'd0);
    check("frz_evt0",  m_evt[31:0], 32'd0);
    check("frz_state", 32'(m_state), 32'd2);

    // Timeout at 16 cycles with a changing PC
    do_clear();
    enable = 1'b1; debug_pc = 32'h300; debug_instr = 32'h0000_0033;
    tick();
    for (int k = 1; k <= 16; k++) begin
      debug_pc = 32'h300 + 32'(4 * k);
      tick();
      if (k == 15) check("to_pre_state", 32'(m_state), 32'd1);
    end
    check("to_state", 32'(m_state), 32'd3);
    check("to_cycle", m_cycle, 32'd16);
    check("to_done",  32'(m_done), 32'd1);
    for (int k = 0; k < 3; k++) begin
      debug_pc = 32'h400 + 32'(4 * k);
      tick();
    end
    check("to_frz_cycle", m_cycle, 32'd16);
    check("to_frz_state", 32'(m_state), 32'd3);

    // Saturation on 4-bit counters, no timeout over 100 cycles
    do_clear();
    enable = 1'b1; debug_pc = 32'h500; debug_instr = 32'h0000_0033;
    tick();
    for (int k = 1; k <= 100; k++) begin
      debug_pc = 32'h500 + 32'(4 * k);
      evt_in   = (k <= 20) ? 4'b0100 : 4'b0000;
      tick();
      if (k == 10) begin
        check("sat_evt2_mid", 32'(s_evt[11:8]), 32'd10);
        check("sat_ovf_mid",  32'(s_overflow), 32'd0);
      end
    end
    evt_in = 4'd0;
    check("sat_evt2",  32'(s_evt[11:8]), 32'd15);
    check("sat_evt0",  32'(s_evt[3:0]), 32'd0);
    check("sat_ovf",   32'(s_overflow), 32'd1);
    check("sat_cycle", 32'(s_cycle), 32'd15);
    check("nto_state", 32'(s_state), 32'd1);
    check("nto_done",  32'(s_done), 32'd0);

    // Clear on the very edge that would declare the loop halt
    do_clear();
    enable = 1'b1; debug_pc = 32'h40; debug_instr = 32'h0000_006F;
    tick();
    for (int k = 1; k <= 5; k++) tick();
    check("pri_pre_state", 32'(m_state), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("pri_state",   32'(m_state), 32'd0);
    check("pri_done",    32'(m_done), 32'd0);
    check("pri_loop_pc", m_loop_pc, 32'd0);
    check("pri_cycle",   m_cycle, 32'd0);
    check("pri_instr",   m_instr, 32'd0);

    // A zero instruction must not arm the monitor
    enable = 1'b1; debug_instr = 32'd0;
    tick();
    check("arm0_state", 32'(m_state), 32'd0);

    // Reset mid-RUN returns to IDLE with counts zeroed
    debug_instr = 32'h0000_0033; debug_pc = 32'h600;
    tick();
    debug_pc = 32'h604;
    tick();
    check("mid_cycle", m_cycle, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; enable = 1'b0;
    check("mid_rst_state", 32'(m_state), 32'd0);
    check("mid_rst_cycle", m_cycle, 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
